// File: rtl/ps2_keyboard_source_pkg.sv
// Shared definitions for the PS/2 keyboard source: scan-code constants, FSM encodings,
// the odd-parity helper and the set-2 to ASCII table.
package ps2_keyboard_source_pkg;

    localparam logic [7:0] PS2_BREAK          = 8'hF0;
    localparam logic [7:0] PS2_EXT            = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT         = 8'h12;
    localparam logic [7:0] PS2_RSHIFT         = 8'h59;
    localparam logic [7:0] PS2_ESC            = 8'h76;
    localparam logic [7:0] CONSOLE_CLEAR_CHAR = 8'd1;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        DEC_NORMAL    = 2'd0,
        DEC_BREAK     = 2'd1,
        DEC_EXT       = 2'd2,
        DEC_EXT_BREAK = 2'd3
    } dec_state_e;

    typedef enum logic [1:0] {
        STB_IDLE = 2'd0,
        STB_LOAD = 2'd1,
        STB_HIGH = 2'd2
    } stb_state_e;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Returns {hit, char}; hit=0 means the make code produces no console character.
    function automatic logic [8:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        logic       hit;
        ch  = 8'h00;
        hit = 1'b0;
        case (code)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
            8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
            8'h3E: ch = "8";  8'h46: ch = "9";
            8'h55: ch = "=";
            8'h4E: ch = "-";
            8'h5D: ch = "|";
            PS2_ESC: ch = CONSOLE_CLEAR_CHAR;
            default: ch = 8'h00;
        endcase
        if ((ch >= "a") && (ch <= "z")) begin
            hit = 1'b1;
            ch  = shift ? (ch - 8'h20) : ch;
        end else if ((ch >= "0") && (ch <= "9")) begin
            hit = ~shift;
        end else if (ch == "|") begin
            hit = shift;
        end else begin
            hit = (ch != 8'h00);
        end
        return {hit, ch};
    endfunction

endpackage

// File: rtl/ps2_keyboard_source_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter, frame FSM
// with inter-edge timeout. Parity checking is built only when PS2_PARITY_CHECK_EN is defined.
module ps2_keyboard_source_frame_rx
    import ps2_keyboard_source_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic              clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_s;
    rx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
    logic              parity_q, parity_d;
`endif

    // Idle-high reset of the synchronisers keeps a spurious falling edge out of reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= {FILT_W{1'b0}};
            state_q    <= RX_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tmo_cnt_q  <= {TMO_W{1'b0}};
            byte_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            clk_meta_q <= ps2_clk_i;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat_i;
            dat_sync_q <= dat_meta_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_cnt_q  <= tmo_cnt_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = {FILT_W{1'b0}};
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end else begin
            filt_cnt_d = {FILT_W{1'b0}};
        end
        fall_s = filt_q & ~filt_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_cnt_d = {TMO_W{1'b0}};
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif
        if ((state_q != RX_IDLE) && !fall_s) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d = RX_IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = {TMO_W{1'b0}};
        end
        if (fall_s) begin
            case (state_q)
                RX_IDLE: begin
                    bit_cnt_d = 3'd0;
                    state_d   = dat_sync_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
                end
                RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dat_sync_q;
`endif
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (dat_sync_q) begin
`ifdef PS2_PARITY_CHECK_EN
                        if (odd_parity_ok(shift_q, parity_q)) begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
`else
                        byte_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else begin
            shift_d = shift_q;
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ps2_keyboard_source.sv
// PS/2 keyboard to VGA text console source: scan-code set 2 decode, shift tracking and the
// KeyboardInput/AdvanceCursor strobe handshake. Optional parity check: PS2_PARITY_CHECK_EN.
module ps2_keyboard_source
    import ps2_keyboard_source_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STROBE_CYCLES  = 4
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] KeyboardInput,
    output logic       AdvanceCursor,
    output logic [7:0] oScanCode,
    output logic       oFrameValid,
    output logic       oParityErr
);

    localparam int STB_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES - 1);

    logic [7:0]       rx_byte_s;
    logic             rx_valid_s;
    logic [8:0]       map_s;
    logic             emit_s;
    logic [7:0]       emit_char_s;
    dec_state_e       dec_q, dec_d;
    logic             shift_q, shift_d;
    stb_state_e       stb_q, stb_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [7:0]       kbd_q, kbd_d;
    logic             adv_q, adv_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_char_q, pend_char_d;

    ps2_keyboard_source_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ps2_frame_rx (
        .clk_i     (iVGA_CLK),
        .rst_i     (iRST),
        .ps2_clk_i (iPS2_CLK),
        .ps2_dat_i (iPS2_DAT),
        .byte_o    (rx_byte_s),
        .valid_o   (rx_valid_s),
        .err_o     (oParityErr)
    );

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            dec_q        <= DEC_NORMAL;
            shift_q      <= 1'b0;
            stb_q        <= STB_IDLE;
            stb_cnt_q    <= {STB_W{1'b0}};
            kbd_q        <= 8'h00;
            adv_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_char_q  <= 8'h00;
        end else begin
            dec_q        <= dec_d;
            shift_q      <= shift_d;
            stb_q        <= stb_d;
            stb_cnt_q    <= stb_cnt_d;
            kbd_q        <= kbd_d;
            adv_q        <= adv_d;
            pend_valid_q <= pend_valid_d;
            pend_char_q  <= pend_char_d;
        end
    end

    always_comb begin
        dec_d       = dec_q;
        shift_d     = shift_q;
        emit_s      = 1'b0;
        emit_char_s = 8'h00;
        map_s       = ps2_to_ascii(rx_byte_s, shift_q);
        if (rx_valid_s) begin
            case (dec_q)
                DEC_NORMAL: begin
                    if (rx_byte_s == PS2_BREAK) begin
                        dec_d = DEC_BREAK;
                    end else if (rx_byte_s == PS2_EXT) begin
                        dec_d = DEC_EXT;
                    end else if ((rx_byte_s == PS2_LSHIFT) || (rx_byte_s == PS2_RSHIFT)) begin
                        shift_d = 1'b1;
                    end else begin
                        emit_s      = map_s[8];
                        emit_char_s = map_s[7:0];
                    end
                end
                DEC_BREAK: begin
                    dec_d = DEC_NORMAL;
                    if ((rx_byte_s == PS2_LSHIFT) || (rx_byte_s == PS2_RSHIFT)) begin
                        shift_d = 1'b0;
                    end else begin
                        shift_d = shift_q;
                    end
                end
                DEC_EXT:       dec_d = (rx_byte_s == PS2_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
                DEC_EXT_BREAK: dec_d = DEC_NORMAL;
                default:       dec_d = DEC_NORMAL;
            endcase
        end else begin
            dec_d = dec_q;
        end
    end

    // Strobe sequencer: LOAD holds the new character one clock before AdvanceCursor rises;
    // emits arriving outside IDLE land in the single pending slot (newest wins).
    always_comb begin
        stb_d        = stb_q;
        stb_cnt_d    = stb_cnt_q;
        kbd_d        = kbd_q;
        pend_valid_d = pend_valid_q;
        pend_char_d  = pend_char_q;
        case (stb_q)
            STB_IDLE: begin
                if (pend_valid_q) begin
                    kbd_d        = pend_char_q;
                    stb_d        = STB_LOAD;
                    pend_valid_d = emit_s;
                    pend_char_d  = emit_char_s;
                end else if (emit_s) begin
                    kbd_d = emit_char_s;
                    stb_d = STB_LOAD;
                end else begin
                    stb_d = STB_IDLE;
                end
            end
            STB_LOAD, STB_HIGH: begin
                if (stb_q == STB_LOAD) begin
                    stb_d     = STB_HIGH;
                    stb_cnt_d = {STB_W{1'b0}};
                end else if (stb_cnt_q == STB_LAST) begin
                    stb_d = STB_IDLE;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
                if (emit_s) begin
                    pend_valid_d = 1'b1;
                    pend_char_d  = emit_char_s;
                end else begin
                    pend_valid_d = pend_valid_q;
                end
            end
            default: stb_d = STB_IDLE;
        endcase
        adv_d = (stb_d == STB_HIGH);
    end

    assign KeyboardInput = kbd_q;
    assign AdvanceCursor = adv_q;
    assign oScanCode     = rx_byte_s;
    assign oFrameValid   = rx_valid_s;

endmodule

// File: tb/tb_ps2_keyboard_source.sv
// Directed bench for ps2_keyboard_source: a slow PS/2 model drives the main instance, a fast
// model drives a FILTER_LEN=1 / long-strobe instance to exercise the pending slot.
module tb_ps2_keyboard_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] kbd, scan, kbd_p, scan_p;
    logic       adv, fv, pe, adv_p, fv_p, pe_p;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    ps2_keyboard_source #(.FILTER_LEN(8), .TIMEOUT_CYCLES(4000), .STROBE_CYCLES(4)) dut (
        .iVGA_CLK(clk), .iRST(rst), .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
        .KeyboardInput(kbd), .AdvanceCursor(adv), .oScanCode(scan),
        .oFrameValid(fv), .oParityErr(pe));

    ps2_keyboard_source #(.FILTER_LEN(1), .TIMEOUT_CYCLES(4000), .STROBE_CYCLES(32)) dut_p (
        .iVGA_CLK(clk), .iRST(rst), .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
        .KeyboardInput(kbd_p), .AdvanceCursor(adv_p), .oScanCode(scan_p),
        .oFrameValid(fv_p), .oParityErr(pe_p));

    logic [7:0] emit_q[$];
    logic [7:0] emit_p[$];
    logic       adv_prev = 1'b0, adv_p_prev = 1'b0;
    logic [7:0] kbd_prev = 8'h00;
    int high_cnt = 0, high_len_last = 0, stable_bad = 0, valid_cnt = 0, err_cnt = 0;
    int high_p = 0, high_p_last = 0, low_p = 0, gap_min_p = 1000, valid_p_cnt = 0, err_p_cnt = 0;
    bit seen_fall_p = 1'b0;

    always @(negedge clk) begin
        if (adv && !adv_prev) begin
            emit_q.push_back(kbd);
            if (kbd !== kbd_prev) stable_bad++;
            high_cnt = 1;
        end else if (adv) begin
            high_cnt++;
        end else if (adv_prev) begin
            high_len_last = high_cnt;
        end
        if (fv) valid_cnt++;
        if (pe) err_cnt++;
        adv_prev = adv;
        kbd_prev = kbd;
    end

    always @(negedge clk) begin
        if (adv_p && !adv_p_prev) begin
            emit_p.push_back(kbd_p);
            if (seen_fall_p && (low_p < gap_min_p)) gap_min_p = low_p;
            high_p = 1;
        end else if (adv_p) begin
            high_p++;
        end else if (adv_p_prev) begin
            high_p_last = high_p;
            seen_fall_p = 1'b1;
            low_p = 1;
        end else begin
            low_p++;
        end
        if (fv_p) valid_p_cnt++;
        if (pe_p) err_p_cnt++;
        adv_p_prev = adv_p;
    end

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits, input int hp);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (hp) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (hp) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 20);
        repeat (30) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (kbd !== 8'h00) begin failures++; $display("FAIL reset_kbd got=%h want=00", kbd); end
        checks++; if (adv !== 1'b0) begin failures++; $display("FAIL reset_adv got=%b want=0", adv); end
        checks++; if (scan !== 8'h00) begin failures++; $display("FAIL reset_scan got=%h want=00", scan); end
        checks++; if (fv !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b want=0", fv); end
        checks++; if (pe !== 1'b0) begin failures++; $display("FAIL reset_pe got=%b want=0", pe); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (emit_q.size() !== 0) begin failures++; $display("FAIL reset_no_emit got=%0d want=0", emit_q.size()); end
    endtask

    task automatic test_single_key();
        int base = emit_q.size();
        int vb = valid_cnt;
        send(8'h1C);
        checks++; if (emit_q.size() !== base + 1) begin failures++; $display("FAIL single_count got=%0d want=%0d", emit_q.size(), base + 1); end
        checks++; if (emit_q.size() > base && emit_q[base] !== 8'h61) begin failures++; $display("FAIL single_char got=%h want=61", emit_q[base]); end
        checks++; if (high_len_last !== 4) begin failures++; $display("FAIL single_strobe_len got=%0d want=4", high_len_last); end
        checks++; if (scan !== 8'h1C) begin failures++; $display("FAIL single_scan got=%h want=1c", scan); end
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("FAIL single_valid got=%0d want=1", valid_cnt - vb); end
        checks++; if (stable_bad !== 0) begin failures++; $display("FAIL single_kbd_stable got=%0d want=0", stable_bad); end
        repeat (50) @(negedge clk);
        checks++; if (kbd !== 8'h61) begin failures++; $display("FAIL single_hold got=%h want=61", kbd); end
    endtask

    task automatic test_shift_sequence();
        int base = emit_q.size();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        checks++; if (emit_q.size() !== base + 2) begin failures++; $display("FAIL shift_count got=%0d want=%0d", emit_q.size(), base + 2); end
        checks++; if (emit_q.size() > base && emit_q[base] !== 8'h41) begin failures++; $display("FAIL shift_upper got=%h want=41", emit_q[base]); end
        checks++; if (emit_q.size() > base + 1 && emit_q[base + 1] !== 8'h61) begin failures++; $display("FAIL shift_lower got=%h want=61", emit_q[base + 1]); end
    endtask

    task automatic test_map();
        int base = emit_q.size();
        logic [7:0] exp [5];
        exp[0] = 8'h01; exp[1] = 8'h3D; exp[2] = 8'h2D; exp[3] = 8'h30; exp[4] = 8'h7C;
        send(8'h76); send(8'h55); send(8'h4E); send(8'h45); send(8'h5D);
        send(8'h12); send(8'h5D); send(8'h16); send(8'hF0); send(8'h12);
        send(8'hE0); send(8'h75);
        checks++; if (emit_q.size() !== base + 5) begin failures++; $display("FAIL map_count got=%0d want=%0d", emit_q.size(), base + 5); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (emit_q.size() > base + i && emit_q[base + i] !== exp[i]) begin
                failures++; $display("FAIL map_char%0d got=%h want=%h", i, emit_q[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_parity();
        int base = emit_q.size();
        int vb = valid_cnt;
        int eb = err_cnt;
        send_frame(8'h1C, 1'b1, 11, 20);
        repeat (30) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        checks++; if (err_cnt - eb !== 1) begin failures++; $display("FAIL parity_err got=%0d want=1", err_cnt - eb); end
        checks++; if (emit_q.size() !== base) begin failures++; $display("FAIL parity_no_emit got=%0d want=%0d", emit_q.size(), base); end
        checks++; if (valid_cnt !== vb) begin failures++; $display("FAIL parity_no_valid got=%0d want=%0d", valid_cnt, vb); end
`else
        checks++; if (err_cnt !== eb) begin failures++; $display("FAIL parity_err got=%0d want=%0d", err_cnt, eb); end
        checks++; if (emit_q.size() !== base + 1) begin failures++; $display("FAIL parity_emit got=%0d want=%0d", emit_q.size(), base + 1); end
        checks++; if (emit_q.size() > base && emit_q[base] !== 8'h61) begin failures++; $display("FAIL parity_char got=%h want=61", emit_q[base]); end
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("FAIL parity_valid got=%0d want=1", valid_cnt - vb); end
`endif
    endtask

    task automatic test_timeout();
        int base = emit_q.size();
        int vb = valid_cnt;
        send_frame(8'h2D, 1'b0, 5, 20);
        repeat (5000) @(negedge clk);
        send(8'h2D);
        checks++; if (emit_q.size() !== base + 1) begin failures++; $display("FAIL timeout_count got=%0d want=%0d", emit_q.size(), base + 1); end
        checks++; if (emit_q.size() > base && emit_q[base] !== 8'h72) begin failures++; $display("FAIL timeout_char got=%h want=72", emit_q[base]); end
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("FAIL timeout_valid got=%0d want=1", valid_cnt - vb); end
        send(8'h1C);
        checks++; if (emit_q.size() > base + 1 && emit_q[base + 1] !== 8'h61) begin failures++; $display("FAIL timeout_next got=%h want=61", emit_q[base + 1]); end
        else if (emit_q.size() <= base + 1) begin failures++; $display("FAIL timeout_next got=none want=61"); end
    endtask

    task automatic test_reset_midway();
        int base;
        int n;
        send_frame(8'h32, 1'b0, 4, 20);
        #2 rst = 1'b1;
        #1;
        checks++; if (kbd !== 8'h00) begin failures++; $display("FAIL rstframe_kbd got=%h want=00", kbd); end
        checks++; if (scan !== 8'h00) begin failures++; $display("FAIL rstframe_scan got=%h want=00", scan); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1'b0, 10, 20);
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (!adv && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (adv !== 1'b1) begin failures++; $display("FAIL rststrobe_wait got=%b want=1", adv); end
        #2 rst = 1'b1;
        #1;
        checks++; if (adv !== 1'b0) begin failures++; $display("FAIL rststrobe_adv got=%b want=0", adv); end
        checks++; if (kbd !== 8'h00) begin failures++; $display("FAIL rststrobe_kbd got=%h want=00", kbd); end
        checks++; if (scan !== 8'h00) begin failures++; $display("FAIL rststrobe_scan got=%h want=00", scan); end
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        base = emit_q.size();
        send(8'h1C);
        checks++; if (emit_q.size() !== base + 1) begin failures++; $display("FAIL rst_recover_count got=%0d want=%0d", emit_q.size(), base + 1); end
        checks++; if (kbd !== 8'h61) begin failures++; $display("FAIL rst_recover_char got=%h want=61", kbd); end
    endtask

    task automatic test_back_to_back();
        int base;
        int vb;
        int eb;
        pulse_reset();
        base = emit_p.size();
        vb = valid_p_cnt;
        eb = err_p_cnt;
        send_frame(8'h1C, 1'b0, 11, 1);
        send_frame(8'h32, 1'b0, 11, 1);
        repeat (150) @(negedge clk);
        checks++; if (emit_p.size() !== base + 2) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", emit_p.size(), base + 2); end
        checks++; if (emit_p.size() > base && emit_p[base] !== 8'h61) begin failures++; $display("FAIL b2b_first got=%h want=61", emit_p[base]); end
        checks++; if (emit_p.size() > base + 1 && emit_p[base + 1] !== 8'h62) begin failures++; $display("FAIL b2b_second got=%h want=62", emit_p[base + 1]); end
        checks++; if (gap_min_p < 1 || gap_min_p == 1000) begin failures++; $display("FAIL b2b_low_gap got=%0d want>=1", gap_min_p); end
        checks++; if (high_p_last !== 32) begin failures++; $display("FAIL b2b_strobe_len got=%0d want=32", high_p_last); end
        checks++; if (scan_p !== 8'h32) begin failures++; $display("FAIL b2b_scan got=%h want=32", scan_p); end
        checks++; if (valid_p_cnt - vb !== 2) begin failures++; $display("FAIL b2b_valid got=%0d want=2", valid_p_cnt - vb); end
        checks++; if (err_p_cnt !== eb) begin failures++; $display("FAIL b2b_err got=%0d want=%0d", err_p_cnt, eb); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_shift_sequence();
        test_map();
        test_parity();
        test_timeout();
        test_reset_midway();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
